// File: rtl/alu_op_sequencer.sv
// Sequencer that runs a small {opcode, operand} program through an external ALU.
// Optional early stop on ALU error: define ALU_SEQ_ERROR_HALT_EN.
module alu_op_sequencer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [3:0]        load_op,
    input  logic [15:0]       load_operand,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              start,
    output logic [3:0]        alu_opcode,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    input  logic [32:0]       alu_c,
    input  logic [1:0]        alu_error,
    output logic              busy,
    output logic              done,
    output logic [32:0]       result,
    output logic [1:0]        err_sticky,
    output logic [ADDR_W-1:0] halted_at
);

    localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CW-1:0] HOLD_LOAD =
        CW'((ALU_LATENCY > 0) ? ALU_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        CAPTURE,
        FINISH
    } state_t;

    state_t state, state_n;

    logic [19:0]       mem [DEPTH];
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] last_q;
    logic [CW-1:0]     hold_cnt;
    logic [19:0]       entry;
    logic              active;
    logic              stop;

    assign entry  = mem[pc];
    assign active = (state == ISSUE) || (state == HOLD) ||
                    (state == CAPTURE);

    assign alu_opcode = active ? entry[19:16] : 4'b0000;
    assign alu_a      = active ? entry[15:0] : 16'd0;
    assign busy       = active;
    assign done       = (state == FINISH);

`ifdef ALU_SEQ_ERROR_HALT_EN
    assign stop = (pc == last_q) || (alu_error != 2'b00);
`else
    assign stop = (pc == last_q);
`endif

    // Program memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (load_en && state == IDLE) begin
            mem[load_addr] <= {load_op, load_operand};
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) state_n = ISSUE;
            end
            ISSUE: begin
                state_n = (ALU_LATENCY == 0) ? CAPTURE : HOLD;
            end
            HOLD: begin
                if (hold_cnt == '0) state_n = CAPTURE;
            end
            CAPTURE: begin
                state_n = stop ? FINISH : ISSUE;
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= '0;
            last_q     <= '0;
            hold_cnt   <= '0;
            alu_b      <= '0;
            result     <= '0;
            err_sticky <= '0;
            halted_at  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pc         <= '0;
                        last_q     <= last_addr;
                        err_sticky <= '0;
                        alu_b      <= '0;
                    end
                end
                ISSUE: begin
                    hold_cnt <= HOLD_LOAD;
                end
                HOLD: begin
                    if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                end
                CAPTURE: begin
                    result     <= alu_c;
                    halted_at  <= pc;
                    err_sticky <= err_sticky | alu_error;
                    // Chain low half of the result into the next B operand.
                    if (!stop) begin
                        pc    <= pc + 1'b1;
                        alu_b <= alu_c[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
